alu_rr_arbiter: RTL and testbench

Shares one `ALU` instance between `N_REQ` requesters, such as issue lanes or a multi-cycle sequencer, using round-robin arbitration. Each request and each response uses a valid/ready handshake. The block registers the ALU result in a single-entry response buffer tagged with the requester index. Upstream units can therefore hold pending operations without owning an ALU.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_rr_arbiter_alu.sv | 34 +++
 rtl/alu_rr_arbiter.sv | 114 +++++++++++
 tb/tb_alu_rr_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg : opcode encodings shared by ALU and alu_rr_arbiter          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;
  localparam int OPC_W = 6;
  localparam int DATA_W = 32;

  localparam logic [OPC_W-1:0] ADD = 6'd0;
  localparam logic [OPC_W-1:0] SUB = 6'd1;
  localparam logic [OPC_W-1:0] AND = 6'd2;
  localparam logic [OPC_W-1:0] OR  = 6'd3;
  localparam logic [OPC_W-1:0] XOR = 6'd4;
  localparam logic [OPC_W-1:0] SHL = 6'd6;
  localparam logic [OPC_W-1:0] SHR = 6'd7;
  localparam logic [OPC_W-1:0] SRA = 6'd8;
  localparam logic [OPC_W-1:0] SLT = 6'd9;
endpackage

`default_nettype wire

// File: rtl/alu_rr_arbiter_alu.sv
// +----------------------------------------------------------------------+
// | ALU : combinational 32-bit ALU; undecoded opcodes yield zero         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ALU
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_opcode)
      ADD:     o_y = i_a + i_b;
      SUB:     o_y = i_a - i_b;
      AND:     o_y = i_a & i_b;
      OR:      o_y = i_a | i_b;
      XOR:     o_y = i_a ^ i_b;
      SHL:     o_y = i_a << i_b[4:0];
      SHR:     o_y = i_a >> i_b[4:0];
      SRA:     o_y = $unsigned($signed(i_a) >>> i_b[4:0]);
      SLT:     o_y = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | alu_rr_arbiter : round-robin sharing of one ALU among N_REQ lanes,   |
// | with a single-entry tagged response buffer                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OPC_W-1:0]  req_opcode,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id
);

  // Returns {found, index}; scanning offsets high-to-low lets the lowest offset win.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [ID_W-1:0]   r_rsp_id;
  logic [ID_W-1:0]   r_rr_ptr;

  logic [ID_W:0]     w_pick;
  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic              w_can_issue;
  logic              w_fire;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [OPC_W-1:0]  w_opcode;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu_y;

  logic [OPC_W-1:0]  w_op_arr [N_REQ];
  logic [DATA_W-1:0] w_a_arr  [N_REQ];
  logic [DATA_W-1:0] w_b_arr  [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_op_arr[gi] = req_opcode[gi*OPC_W +: OPC_W];
      assign w_a_arr[gi]  = req_a[gi*DATA_W +: DATA_W];
      assign w_b_arr[gi]  = req_b[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_pick      = rr_pick(req_valid, r_rr_ptr);
  assign w_found     = w_pick[ID_W];
  assign w_win       = w_pick[ID_W-1:0];
  assign w_can_issue = !r_rsp_valid || rsp_ready;
  assign w_fire      = w_found && w_can_issue;
  assign w_ptr_nxt   = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;

  assign w_opcode = w_op_arr[w_win];
  assign w_a      = w_a_arr[w_win];
  assign w_b      = w_b_arr[w_win];

  always_comb begin
    req_ready = '0;
    if (w_fire) req_ready[w_win] = 1'b1;
  end

  ALU u_alu (
    .i_opcode (w_opcode),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_y      (w_alu_y)
  );

  // A refill takes priority over a drain so rsp_valid stays high when both happen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_alu_y;
      r_rsp_id    <= w_win;
      r_rr_ptr    <= w_ptr_nxt;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_alu_rr_arbiter : self-checking bench for alu_rr_arbiter           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N_REQ = 2 instance
  logic [1:0]  a_req_valid = '0;
  logic [1:0]  a_req_ready;
  logic [11:0] a_req_opcode = '0;
  logic [63:0] a_req_a = '0;
  logic [63:0] a_req_b = '0;
  logic        a_rsp_valid;
  logic        a_rsp_ready = 1'b1;
  logic [31:0] a_rsp_data;
  logic [0:0]  a_rsp_id;

  // N_REQ = 4 instance
  logic [3:0]   b_req_valid = '0;
  logic [3:0]   b_req_ready;
  logic [23:0]  b_req_opcode = '0;
  logic [127:0] b_req_a = '0;
  logic [127:0] b_req_b = '0;
  logic         b_rsp_valid;
  logic         b_rsp_ready = 1'b1;
  logic [31:0]  b_rsp_data;
  logic [1:0]   b_rsp_id;

  alu_rr_arbiter #(.N_REQ(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_opcode(a_req_opcode), .req_a(a_req_a), .req_b(a_req_b),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_data(a_rsp_data), .rsp_id(a_rsp_id)
  );

  alu_rr_arbiter #(.N_REQ(4)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_opcode(b_req_opcode), .req_a(b_req_a), .req_b(b_req_b),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data), .rsp_id(b_rsp_id)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the N_REQ=2 instance: next-to-serve index and the buffer.
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [0:0]  m_id    = '0;

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    int sh;
    longint sx, sy;
    sh = int'(y % 32);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      6'd0: return x + y;
      6'd1: return x - y;
      6'd2: return x & y;
      6'd3: return x | y;
      6'd4: return x ^ y;
      6'd6: return x << sh;
      6'd7: return x >> sh;
      6'd8: return 32'(sx >>> sh);
      6'd9: return (sx < sy) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < 2; k++)
      if (a_req_valid[(m_ptr + k) % 2]) return (m_ptr + k) % 2;
    return -1;
  endfunction

  function automatic logic [1:0] model_ready();
    int w;
    logic [1:0] r;
    w = model_winner();
    r = '0;
    if (w >= 0 && (!m_valid || a_rsp_ready)) r[w] = 1'b1;
    return r;
  endfunction

  task automatic step();
    int w;
    logic fire;
    logic [31:0] res;
    w    = model_winner();
    fire = (w >= 0) && (!m_valid || a_rsp_ready);
    res  = '0;
    if (fire) res = ref_alu(a_req_opcode[w*6 +: 6], a_req_a[w*32 +: 32], a_req_b[w*32 +: 32]);
    @(posedge clk);
    #1;
    if (fire) begin
      m_valid = 1'b1;
      m_data  = res;
      m_id    = 1'(w);
      m_ptr   = (w + 1) % 2;
    end else if (m_valid && a_rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic set_a(input int i, input logic v, input logic [5:0] op,
                       input logic [31:0] x, input logic [31:0] y);
    a_req_valid[i]        = v;
    a_req_opcode[i*6 +: 6] = op;
    a_req_a[i*32 +: 32]   = x;
    a_req_b[i*32 +: 32]   = y;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = '0;
  endtask

  task automatic test_reset();
    a_req_valid = '0;
    do_reset();
    n_checks++;
    if (a_rsp_valid !== 1'b0 || a_rsp_data !== 32'd0 || a_rsp_id !== 1'b0) begin
      $display("FAIL reset_outputs valid=%b data=%h id=%h required 0/0/0", a_rsp_valid, a_rsp_data, a_rsp_id);
    end else n_pass++;
    #1;
    n_checks++;
    if (a_req_ready !== 2'b00) $display("FAIL reset_idle_ready got=%b required=00", a_req_ready);
    else n_pass++;
    set_a(1, 1'b1, 6'd0, 32'd1, 32'd1);
    #1;
    n_checks++;
    if (a_req_ready !== 2'b10) $display("FAIL reset_wrap_ready got=%b required=10", a_req_ready);
    else n_pass++;
    a_req_valid = '0;
  endtask

  task automatic test_single_add();
    do_reset();
    a_rsp_ready = 1'b1;
    set_a(0, 1'b1, 6'd0, 32'd5, 32'd7);
    #1;
    n_checks++;
    if (a_req_ready !== 2'b01) $display("FAIL add_ready got=%b required=01", a_req_ready);
    else n_pass++;
    step();
    n_checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'd12 || a_rsp_id !== 1'b0)
      $display("FAIL add_rsp valid=%b data=%0d id=%0d required 1/12/0", a_rsp_valid, a_rsp_data, a_rsp_id);
    else n_pass++;
    set_a(0, 1'b1, 6'd0, 32'd1, 32'd2);
    set_a(1, 1'b1, 6'd0, 32'd3, 32'd4);
    #1;
    n_checks++;
    if (a_req_ready !== 2'b10) $display("FAIL add_ptr_advance got=%b required=10", a_req_ready);
    else n_pass++;
    a_req_valid = '0;
    step();
    step();
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_d;
    do_reset();
    a_rsp_ready = 1'b1;
    set_a(0, 1'b1, 6'd1, 32'd10, 32'd3);
    set_a(1, 1'b1, 6'd9, 32'hFFFF_FFFF, 32'd2);
    for (int c = 0; c < 4; c++) begin
      exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_d   = (c % 2 == 0) ? 32'd7 : 32'd1;
      #1;
      n_checks++;
      if (a_req_ready !== exp_rdy) $display("FAIL alt_ready c=%0d got=%b required=%b", c, a_req_ready, exp_rdy);
      else n_pass++;
      step();
      n_checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== exp_d || a_rsp_id !== 1'(c % 2))
        $display("FAIL alt_rsp c=%0d valid=%b data=%0d id=%0d required 1/%0d/%0d",
                 c, a_rsp_valid, a_rsp_data, a_rsp_id, exp_d, c % 2);
      else n_pass++;
    end
  endtask

  // Runs straight after test_alternate: buffer holds req1's SLT result (1), pointer at 0.
  task automatic test_backpressure();
    a_rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (a_req_ready !== 2'b00) $display("FAIL bp_ready c=%0d got=%b required=00", c, a_req_ready);
      else n_pass++;
      step();
      n_checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'd1 || a_rsp_id !== 1'b1)
        $display("FAIL bp_hold c=%0d valid=%b data=%0d id=%0d required 1/1/1", c, a_rsp_valid, a_rsp_data, a_rsp_id);
      else n_pass++;
    end
    a_rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (a_req_ready !== 2'b01) $display("FAIL bp_release_ready got=%b required=01", a_req_ready);
    else n_pass++;
    step();
    n_checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'd7 || a_rsp_id !== 1'b0)
      $display("FAIL bp_refill valid=%b data=%0d id=%0d required 1/7/0", a_rsp_valid, a_rsp_data, a_rsp_id);
    else n_pass++;
    a_req_valid = '0;
  endtask

  task automatic test_sra_unused();
    do_reset();
    a_rsp_ready = 1'b1;
    set_a(1, 1'b1, 6'd8, 32'h8000_0000, 32'd4);
    #1;
    n_checks++;
    if (a_req_ready !== 2'b10) $display("FAIL sra_ready got=%b required=10", a_req_ready);
    else n_pass++;
    step();
    n_checks++;
    if (a_rsp_data !== 32'hF800_0000 || a_rsp_id !== 1'b1)
      $display("FAIL sra_rsp data=%h id=%0d required f8000000/1", a_rsp_data, a_rsp_id);
    else n_pass++;
    a_req_valid = '0;
    set_a(0, 1'b1, 6'h3F, 32'h1234_5678, 32'h9ABC_DEF0);
    #1;
    step();
    n_checks++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'd0 || a_rsp_id !== 1'b0)
      $display("FAIL unused_op valid=%b data=%h id=%0d required 1/0/0", a_rsp_valid, a_rsp_data, a_rsp_id);
    else n_pass++;
    a_req_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    a_rsp_ready = 1'b1;
    set_a(1, 1'b1, 6'd0, 32'd40, 32'd2);
    step();
    a_req_valid = '0;
    set_a(0, 1'b1, 6'd3, 32'hF0, 32'h0F);
    set_a(1, 1'b1, 6'd2, 32'hFF, 32'h0F);
    a_rsp_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (a_rsp_valid !== 1'b0 || a_rsp_data !== 32'd0 || a_rsp_id !== 1'b0)
      $display("FAIL async_rst valid=%b data=%h id=%0d required 0/0/0", a_rsp_valid, a_rsp_data, a_rsp_id);
    else n_pass++;
    #1 rst = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = '0;
    #1;
    n_checks++;
    if (a_req_ready !== 2'b01) $display("FAIL async_first_grant got=%b required=01", a_req_ready);
    else n_pass++;
    step();
    n_checks++;
    if (a_rsp_id !== 1'b0 || a_rsp_data !== 32'hFF)
      $display("FAIL async_first_rsp data=%h id=%0d required ff/0", a_rsp_data, a_rsp_id);
    else n_pass++;
    a_req_valid = '0;
  endtask

  task automatic test_random();
    logic [1:0] acc;
    int k;
    logic [5:0] op;
    do_reset();
    acc = '0;
    for (int c = 0; c < 250; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!a_req_valid[i] || acc[i]) begin
          k  = int'($urandom_range(0, 11));
          op = (k == 11) ? 6'h3F : 6'(k);
          set_a(i, ($urandom % 4) != 0, op, $urandom, ($urandom % 2 == 0) ? $urandom : ($urandom % 40));
        end
      end
      a_rsp_ready = ($urandom % 3) != 0;
      #1;
      acc = model_ready();
      n_checks++;
      if (a_req_ready !== acc) $display("FAIL rnd_ready c=%0d got=%b required=%b", c, a_req_ready, acc);
      else n_pass++;
      step();
      n_checks++;
      if (a_rsp_valid !== m_valid || a_rsp_data !== m_data || a_rsp_id !== m_id)
        $display("FAIL rnd_rsp c=%0d valid=%b data=%h id=%0d required %b/%h/%0d",
                 c, a_rsp_valid, a_rsp_data, a_rsp_id, m_valid, m_data, m_id);
      else n_pass++;
    end
    a_req_valid = '0;
  endtask

  task automatic test_n4();
    do_reset();
    b_rsp_ready = 1'b1;
    b_req_valid = 4'b0010;
    b_req_opcode[1*6 +: 6] = 6'd0;
    b_req_a[1*32 +: 32] = 32'd1;
    b_req_b[1*32 +: 32] = 32'd1;
    #1;
    n_checks++;
    if (b_req_ready !== 4'b0010) $display("FAIL n4_prime_ready got=%b required=0010", b_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    b_req_valid = 4'b1010;
    b_req_opcode[1*6 +: 6] = 6'd4;
    b_req_a[1*32 +: 32] = 32'hFF00;
    b_req_b[1*32 +: 32] = 32'h0FF0;
    b_req_opcode[3*6 +: 6] = 6'd0;
    b_req_a[3*32 +: 32] = 32'd100;
    b_req_b[3*32 +: 32] = 32'd1;
    #1;
    n_checks++;
    if (b_req_ready !== 4'b1000) $display("FAIL n4_first_ready got=%b required=1000", b_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_id !== 2'd3 || b_rsp_data !== 32'd101)
      $display("FAIL n4_first_rsp valid=%b id=%0d data=%0d required 1/3/101", b_rsp_valid, b_rsp_id, b_rsp_data);
    else n_pass++;
    b_req_valid = 4'b0010;
    #1;
    n_checks++;
    if (b_req_ready !== 4'b0010) $display("FAIL n4_second_ready got=%b required=0010", b_req_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (b_rsp_id !== 2'd1 || b_rsp_data !== 32'hF0F0)
      $display("FAIL n4_second_rsp id=%0d data=%h required 1/f0f0", b_rsp_id, b_rsp_data);
    else n_pass++;
    b_req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_alternate();
    test_backpressure();
    test_sra_unused();
    test_async_reset();
    test_random();
    test_n4();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout passed=%0d checks=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
